// File: rtl/pll_sup_pkg.sv
//============================================================================
// Module : pll_sup_pkg
// Brief  : Shared state encoding and counter sizing for the PLL supervisor.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // One spare bit above the largest terminal count keeps the counter clear of wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer for level signals crossing into clk.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
//============================================================================
// Module : pll_lock_supervisor
// Brief  : Sequences PLL reset/lock bring-up, qualifies the clock, retries
//          failed locks and latches a fault after too many failures.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 50,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int MAX_RETRY        = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pll_lock,
    input  logic                             clr_fault,
    output logic                             pll_reset,
    output logic                             clk_ok,
    output logic                             fault,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [7:0]                       lock_loss_cnt
);

    localparam int c_cnt_w = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
    localparam int c_rty_w = $clog2(MAX_RETRY + 1);

    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(RST_PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last    = c_cnt_w'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYC - 1);
    localparam logic [c_rty_w-1:0] c_max_retry   = c_rty_w'(MAX_RETRY);

    logic               w_lock_s;
    pll_state_e         r_state;
    pll_state_e         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_rty_w-1:0] r_retry;
    logic [c_rty_w-1:0] w_retry_nxt;
    logic [7:0]         r_loss;
    logic [7:0]         w_loss_nxt;
    logic               r_pll_reset;
    logic               r_clk_ok;
    logic               r_fault;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pll_lock),
        .q    (w_lock_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            ST_RESET: begin
                if (r_cnt == c_rst_last) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == c_tmo_last) begin
                    if (r_retry == c_max_retry) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_RESET;
                        w_retry_nxt = r_retry + c_rty_w'(1);
                    end
                end
            end
            ST_STABLE: begin
                // A single low sample restarts qualification without costing a retry.
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = '0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_lock_s) begin
                    w_state_nxt = ST_RESET;
                    if (r_loss != 8'hFF) w_loss_nxt = r_loss + 8'd1;
                end
            end
            ST_FAULT: begin
                w_cnt_nxt = '0;
                if (clr_fault) begin
                    w_state_nxt = ST_RESET;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they switch on the entering edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_loss      <= '0;
            r_pll_reset <= 1'b1;
            r_clk_ok    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_loss      <= w_loss_nxt;
            r_pll_reset <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_FAULT);
            r_clk_ok    <= (w_state_nxt == ST_RUN);
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_reset     = r_pll_reset;
    assign clk_ok        = r_clk_ok;
    assign fault         = r_fault;
    assign retry_cnt     = r_retry;
    assign lock_loss_cnt = r_loss;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
//============================================================================
// Module : tb_pll_lock_supervisor
// Brief  : Scoreboard bench; stimulus queues timed output events, a monitor
//          pops one per observed output change and compares.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       clr_fault;
    logic       pll_reset;
    logic       clk_ok;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // {pll_reset, clk_ok, fault, retry_cnt, lock_loss_cnt}
    typedef struct packed {
        int          cy;
        logic [12:0] o;
    } ev_t;

    ev_t ev_q[$];

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .MAX_RETRY       (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .clr_fault    (clr_fault),
        .pll_reset    (pll_reset),
        .clk_ok       (clk_ok),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] outs();
        return {pll_reset, clk_ok, fault, retry_cnt, lock_loss_cnt};
    endfunction

    function automatic logic [12:0] pk(input logic r, input logic ok, input logic f,
                                       input logic [1:0] rt, input logic [7:0] ls);
        return {r, ok, f, rt, ls};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int cy, input logic [12:0] o);
        ev_t e;
        e.cy = cy;
        e.o  = o;
        ev_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of any output must match the next queued event.
    initial begin
        logic [12:0] prev;
        logic [12:0] cur;
        ev_t         e;
        prev = pk(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        forever begin
            @(negedge clk);
            cur = outs();
            if (cur !== prev) begin
                if (ev_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_change: got %0h was %0h (cycle %0d)", cur, prev, cyc);
                end else begin
                    e = ev_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cy));
                    check("event_outputs", {19'd0, cur}, {19'd0, e.o});
                end
                prev = cur;
            end
        end
    end

    initial begin
        int c;
        int loss;
        pll_lock  = 1'b0;
        clr_fault = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1 check("reset_state", {19'd0, outs()}, {19'd0, pk(1, 0, 0, 0, 0)});

        // Normal bring-up: lock arrives 10 cycles after release.
        tick(3);
        c = cyc;
        rst_n = 1'b1;
        expect_ev(c + 4,  pk(0, 0, 0, 0, 0));
        expect_ev(c + 21, pk(0, 1, 0, 0, 0));
        tick(10);
        pll_lock = 1'b1;
        tick(15);

        clr_fault = 1'b1;
        tick(1);
        clr_fault = 1'b0;
        tick(2);
        check("clr_fault_ignored", {19'd0, outs()}, {19'd0, pk(0, 1, 0, 0, 0)});

        // One-cycle loss in RUN, then a 2-cycle glitch at stable count 5.
        c = cyc;
        pll_lock = 1'b0;
        expect_ev(c + 3,  pk(1, 0, 0, 0, 1));
        expect_ev(c + 7,  pk(0, 0, 0, 0, 1));
        expect_ev(c + 26, pk(0, 1, 0, 0, 1));
        tick(1);
        pll_lock = 1'b1;
        tick(12);
        pll_lock = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        tick(12);

        // Permanent loss: two retries then fault.
        c = cyc;
        pll_lock = 1'b0;
        expect_ev(c + 3,  pk(1, 0, 0, 0, 2));
        expect_ev(c + 7,  pk(0, 0, 0, 0, 2));
        expect_ev(c + 27, pk(1, 0, 0, 1, 2));
        expect_ev(c + 31, pk(0, 0, 0, 1, 2));
        expect_ev(c + 51, pk(1, 0, 0, 2, 2));
        expect_ev(c + 55, pk(0, 0, 0, 2, 2));
        expect_ev(c + 75, pk(1, 0, 1, 2, 2));
        tick(80);
        pll_lock = 1'b1;
        tick(10);
        check("fault_ignores_lock", {19'd0, outs()}, {19'd0, pk(1, 0, 1, 2, 2)});

        c = cyc;
        clr_fault = 1'b1;
        expect_ev(c + 1,  pk(1, 0, 0, 0, 2));
        expect_ev(c + 5,  pk(0, 0, 0, 0, 2));
        expect_ev(c + 14, pk(0, 1, 0, 0, 2));
        tick(1);
        clr_fault = 1'b0;
        tick(15);

        // Repeated lock losses until the loss counter saturates.
        for (int k = 1; k <= 300; k++) begin
            c = cyc;
            loss = (2 + k > 255) ? 255 : 2 + k;
            pll_lock = 1'b0;
            expect_ev(c + 3,  pk(1, 0, 0, 0, 8'(loss)));
            expect_ev(c + 7,  pk(0, 0, 0, 0, 8'(loss)));
            expect_ev(c + 16, pk(0, 1, 0, 0, 8'(loss)));
            tick(1);
            pll_lock = 1'b1;
            tick(15);
        end
        check("loss_saturated", {24'd0, lock_loss_cnt}, 32'd255);

        // Asynchronous reset between clock edges while in RUN.
        tick(2);
        c = cyc;
        #2;
        expect_ev(c + 1, pk(1, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1 check("async_reset", {19'd0, outs()}, {19'd0, pk(1, 0, 0, 0, 0)});
        tick(3);
        c = cyc;
        rst_n = 1'b1;
        expect_ev(c + 4,  pk(0, 0, 0, 0, 0));
        expect_ev(c + 13, pk(0, 1, 0, 0, 0));
        tick(20);

        check("events_outstanding", 32'(ev_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
